// File: rtl/mc_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mc_ctrl_pkg
// Description : Shared definitions for the multi-cycle controller.
//               - FSM state enum and instruction class enum
//               - Opcode / funct field constants
//               - ALUOp, ExtOp and PCSel output codes
// Revision    : 1.0 - initial release
// ============================================================================
package mc_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_FETCH  = 3'd0,
        ST_DECODE = 3'd1,
        ST_EXEC   = 3'd2,
        ST_MEM    = 3'd3,
        ST_WB     = 3'd4
    } state_t;

    typedef enum logic [3:0] {
        CLS_ILLEGAL = 4'd0,
        CLS_ADDU    = 4'd1,
        CLS_SUBU    = 4'd2,
        CLS_JR      = 4'd3,
        CLS_ORI     = 4'd4,
        CLS_LUI     = 4'd5,
        CLS_LW      = 4'd6,
        CLS_SW      = 4'd7,
        CLS_BEQ     = 4'd8,
        CLS_J       = 4'd9,
        CLS_JAL     = 4'd10
    } instr_class_t;

    // Opcode field values
    localparam logic [5:0] c_op_rtype = 6'b000000;
    localparam logic [5:0] c_op_ori   = 6'b001101;
    localparam logic [5:0] c_op_lui   = 6'b001111;
    localparam logic [5:0] c_op_lw    = 6'b100011;
    localparam logic [5:0] c_op_sw    = 6'b101011;
    localparam logic [5:0] c_op_beq   = 6'b000100;
    localparam logic [5:0] c_op_j     = 6'b000010;
    localparam logic [5:0] c_op_jal   = 6'b000011;

    // Funct field values for R-type
    localparam logic [5:0] c_funct_addu = 6'b100001;
    localparam logic [5:0] c_funct_subu = 6'b100011;
    localparam logic [5:0] c_funct_jr   = 6'b001000;

    // ALU operation codes
    localparam logic [3:0] c_aluop_add = 4'd0;
    localparam logic [3:0] c_aluop_sub = 4'd1;
    localparam logic [3:0] c_aluop_or  = 4'd2;
    localparam logic [3:0] c_aluop_lui = 4'd3;

    // Immediate extension codes
    localparam logic [1:0] c_extop_zero = 2'd0;
    localparam logic [1:0] c_extop_sign = 2'd1;
    localparam logic [1:0] c_extop_high = 2'd2;

    // PC source select codes
    localparam logic [1:0] c_pcsel_pc4    = 2'd0;
    localparam logic [1:0] c_pcsel_branch = 2'd1;
    localparam logic [1:0] c_pcsel_jump   = 2'd2;
    localparam logic [1:0] c_pcsel_reg    = 2'd3;

endpackage : mc_ctrl_pkg
`default_nettype wire

// File: rtl/mc_decode.sv
`default_nettype none
// ============================================================================
// Module      : mc_decode
// Description : Maps the instruction register Op/Funct fields onto an
//               instruction class. Anything outside the supported set
//               decodes to CLS_ILLEGAL.
// Ports       : op[5:0], funct[5:0] - instruction fields (in)
//               instr_class         - decoded class (out)
// Revision    : 1.0 - initial release
// ============================================================================
module mc_decode
    import mc_ctrl_pkg::*;
(
    input  logic [5:0]   op,
    input  logic [5:0]   funct,
    output instr_class_t instr_class
);

    always_comb begin
        instr_class = CLS_ILLEGAL;
        case (op)
            c_op_rtype: begin
                case (funct)
                    c_funct_addu: instr_class = CLS_ADDU;
                    c_funct_subu: instr_class = CLS_SUBU;
                    c_funct_jr:   instr_class = CLS_JR;
                    default:      instr_class = CLS_ILLEGAL;
                endcase
            end
            c_op_ori: instr_class = CLS_ORI;
            c_op_lui: instr_class = CLS_LUI;
            c_op_lw:  instr_class = CLS_LW;
            c_op_sw:  instr_class = CLS_SW;
            c_op_beq: instr_class = CLS_BEQ;
            c_op_j:   instr_class = CLS_J;
            c_op_jal: instr_class = CLS_JAL;
            default:  instr_class = CLS_ILLEGAL;
        endcase
    end

endmodule : mc_decode
`default_nettype wire

// File: rtl/mc_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : mc_ctrl
// Description : Multi-cycle processor control unit. Five-state FSM
//               (FETCH, DECODE, EXEC, MEM, WB), control output decode and
//               retired-instruction counter.
// Ports       : Clk, Reset (async, active low)
//               Op, Funct      - instruction register fields
//               Equal          - ALU compare flag (EXEC)
//               MemReady       - memory completion (FETCH, MEM)
//               PCWrite..IllegalInstr, ALUOp, ExtOp, PCSel - control outputs
//               InstrCount     - retired-instruction counter
// Revision    : 1.0 - initial release
// ============================================================================
module mc_ctrl
    import mc_ctrl_pkg::*;
(
    input  logic        Clk,
    input  logic        Reset,
    input  logic [5:0]  Op,
    input  logic [5:0]  Funct,
    input  logic        Equal,
    input  logic        MemReady,
    output logic        PCWrite,
    output logic        IRWrite,
    output logic        MemRead,
    output logic        MemWrite,
    output logic        RegWrite,
    output logic        RegDst,
    output logic        ALUsrc,
    output logic        MemtoReg,
    output logic        Link,
    output logic        IllegalInstr,
    output logic [3:0]  ALUOp,
    output logic [1:0]  ExtOp,
    output logic [1:0]  PCSel,
    output logic [31:0] InstrCount
);

    state_t       r_state;
    logic [31:0]  r_instr_count;
    instr_class_t w_class;
    logic         w_retire;
    logic         w_ends_in_exec;
    logic         w_needs_mem;

    mc_decode u_decode (
        .op          (Op),
        .funct       (Funct),
        .instr_class (w_class)
    );

    // Control transfers complete in EXEC; loads/stores continue to MEM.
    assign w_ends_in_exec = (w_class == CLS_BEQ) || (w_class == CLS_J) ||
                            (w_class == CLS_JAL) || (w_class == CLS_JR);
    assign w_needs_mem    = (w_class == CLS_LW) || (w_class == CLS_SW);

    // Final cycle of each instruction kind: EXEC for jumps/branches, the
    // completing MEM cycle for sw, WB for everything that writes a register.
    assign w_retire = ((r_state == ST_EXEC) && w_ends_in_exec) ||
                      ((r_state == ST_MEM) && (w_class == CLS_SW) && MemReady) ||
                      (r_state == ST_WB);

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            r_state       <= ST_FETCH;
            r_instr_count <= 32'd0;
        end else begin
            if (w_retire) begin
                r_instr_count <= r_instr_count + 32'd1;
            end
            case (r_state)
                ST_FETCH:  r_state <= MemReady ? ST_DECODE : ST_FETCH;
                ST_DECODE: r_state <= (w_class == CLS_ILLEGAL) ? ST_FETCH : ST_EXEC;
                ST_EXEC: begin
                    if (w_needs_mem) begin
                        r_state <= ST_MEM;
                    end else if (w_ends_in_exec) begin
                        r_state <= ST_FETCH;
                    end else begin
                        r_state <= ST_WB;
                    end
                end
                ST_MEM: begin
                    if (MemReady) begin
                        r_state <= (w_class == CLS_LW) ? ST_WB : ST_FETCH;
                    end
                end
                ST_WB:   r_state <= ST_FETCH;
                default: r_state <= ST_FETCH;
            endcase
        end
    end

    assign InstrCount = r_instr_count;

    // Output decode. Everything is gated by Reset so the outputs fall to
    // zero the instant Reset goes low, without waiting for the state flop.
    always_comb begin
        PCWrite      = 1'b0;
        IRWrite      = 1'b0;
        MemRead      = 1'b0;
        MemWrite     = 1'b0;
        RegWrite     = 1'b0;
        RegDst       = 1'b0;
        ALUsrc       = 1'b0;
        MemtoReg     = 1'b0;
        Link         = 1'b0;
        IllegalInstr = 1'b0;
        ALUOp        = c_aluop_add;
        ExtOp        = c_extop_zero;
        PCSel        = c_pcsel_pc4;
        if (Reset) begin
            case (r_state)
                ST_FETCH: begin
                    MemRead = 1'b1;
                    if (MemReady) begin
                        IRWrite = 1'b1;
                        PCWrite = 1'b1;
                        PCSel   = c_pcsel_pc4;
                    end
                end
                ST_DECODE: begin
                    IllegalInstr = (w_class == CLS_ILLEGAL);
                end
                ST_EXEC: begin
                    case (w_class)
                        CLS_ADDU: ALUOp = c_aluop_add;
                        CLS_SUBU: ALUOp = c_aluop_sub;
                        CLS_ORI: begin
                            ALUOp  = c_aluop_or;
                            ALUsrc = 1'b1;
                            ExtOp  = c_extop_zero;
                        end
                        CLS_LUI: begin
                            ALUOp  = c_aluop_lui;
                            ALUsrc = 1'b1;
                            ExtOp  = c_extop_high;
                        end
                        CLS_LW, CLS_SW: begin
                            ALUOp  = c_aluop_add;
                            ALUsrc = 1'b1;
                            ExtOp  = c_extop_sign;
                        end
                        CLS_BEQ: begin
                            ALUOp   = c_aluop_sub;
                            ExtOp   = c_extop_sign;
                            PCSel   = c_pcsel_branch;
                            PCWrite = Equal;
                        end
                        CLS_J: begin
                            PCWrite = 1'b1;
                            PCSel   = c_pcsel_jump;
                        end
                        CLS_JAL: begin
                            PCWrite  = 1'b1;
                            PCSel    = c_pcsel_jump;
                            RegWrite = 1'b1;
                            Link     = 1'b1;
                        end
                        CLS_JR: begin
                            PCWrite = 1'b1;
                            PCSel   = c_pcsel_reg;
                        end
                        default: ;
                    endcase
                end
                ST_MEM: begin
                    MemRead  = (w_class == CLS_LW);
                    MemWrite = (w_class == CLS_SW);
                end
                ST_WB: begin
                    RegWrite = 1'b1;
                    RegDst   = (w_class == CLS_ADDU) || (w_class == CLS_SUBU);
                    MemtoReg = (w_class == CLS_LW);
                end
                default: ;
            endcase
        end
    end

endmodule : mc_ctrl
`default_nettype wire

// File: doc/mc_ctrl.md
MC_CTRL -- requirements
Module: mc_ctrl

Interface
REQ-001 SHALL have port Clk, input, 1, the single system clock; all state changes on rising edge.
REQ-002 SHALL have port Reset, input, 1, asynchronous active-low reset (Reset=0 resets).
REQ-003 SHALL have inputs Op[5:0] and Funct[5:0], fields of the instruction register, stable from DECODE through instruction end.
REQ-004 SHALL have input Equal (1), the ALU compare flag, valid in EXEC.
REQ-005 SHALL have input MemReady (1), memory completion handshake sampled in FETCH and MEM.
REQ-006 SHALL have outputs PCWrite, IRWrite, MemRead, MemWrite, RegWrite, RegDst, ALUsrc, MemtoReg, Link, IllegalInstr (1 each).
REQ-007 SHALL have outputs ALUOp[3:0], ExtOp[1:0], PCSel[1:0] (0 PC+4, 1 branch, 2 jump target, 3 register).
REQ-008 SHALL have output InstrCount[31:0], the retired-instruction counter.

Function
REQ-009 SHALL implement FSM states FETCH, DECODE, EXEC, MEM, WB.
REQ-010 FETCH SHALL assert MemRead and hold while MemReady=0; on MemReady=1, assert IRWrite and PCWrite with PCSel=0, then go to DECODE.
REQ-011 DECODE SHALL last exactly one cycle and go to EXEC for any supported opcode, else to FETCH with a one-cycle IllegalInstr pulse and no write strobes.
REQ-012 Supported set SHALL be addu, subu, jr (Op=000000, Funct 100001/100011/001000), ori 001101, lui 001111, lw 100011, sw 101011, beq 000100, j 000010, jal 000011.
REQ-013 EXEC SHALL drive ALUOp: ADD for addu/lw/sw, SUB for subu/beq, OR for ori, LUI for lui; ALUsrc=1 for ori/lui/lw/sw; ExtOp ZERO for ori, SIGN for lw/sw/beq, HIGH for lui.
REQ-014 EXEC SHALL go: R-type ALU/ori/lui to WB; lw/sw to MEM; beq/j/jal/jr to FETCH.
REQ-015 beq in EXEC SHALL assert PCWrite with PCSel=1 only when Equal=1.
REQ-016 j/jal in EXEC SHALL assert PCWrite with PCSel=2; jr with PCSel=3; jal SHALL also assert RegWrite and Link (write PC+4 to $31).
REQ-017 MEM SHALL assert MemRead (lw) or MemWrite (sw) and hold while MemReady=0; on MemReady=1, lw goes to WB, sw to FETCH.
REQ-018 WB SHALL assert RegWrite for one cycle; RegDst=1 for R-type, 0 otherwise; MemtoReg=1 only for lw; then go to FETCH.
REQ-019 Write strobes (PCWrite, IRWrite, MemWrite, RegWrite) SHALL each be high at most one cycle per instruction phase.
REQ-020 Latency without wait states SHALL be: R/ori/lui 4, lw 5, sw 4, beq/j/jal/jr 3 cycles.
REQ-021 InstrCount SHALL increment by 1 on the final cycle of every retired instruction (not on illegal), wrapping from FFFF_FFFF to 0.
REQ-022 All outputs SHALL be Moore-style decodes of state and Op/Funct, except MemReady/Equal-qualified strobes.

Reset
REQ-023 Reset=0 SHALL immediately force state FETCH, InstrCount 0, and all control outputs 0, regardless of clock.
REQ-024 Reset asserted mid-instruction SHALL abandon it with no further write strobes; after release, the first cycle SHALL be FETCH.

Structure
REQ-025 A shared package SHALL hold the state enum, opcode/funct constants, ALUOp codes (ADD 0, SUB 1, OR 2, LUI 3), ExtOp codes (ZERO 0, SIGN 1, HIGH 2) and PCSel codes.
REQ-026 One sub-module mc_decode SHALL map Op/Funct to an instruction class; the FSM, counter and output decode stay in mc_ctrl.

Verification
REQ-027 addu with MemReady=1 -> FETCH,DECODE,EXEC,WB; RegWrite=1 RegDst=1 in cycle 4 only; InstrCount 0->1.
REQ-028 lw with MemReady=0 for 3 cycles in MEM -> MEM held 4 cycles, total 8 cycles, MemtoReg=1 with RegWrite in WB.
REQ-029 beq with Equal=0 then Equal=1 -> PCWrite in EXEC only in second case, PCSel=1; both 3 cycles.
REQ-030 jal -> EXEC asserts PCWrite, PCSel=2, RegWrite, Link; back to FETCH next cycle.
REQ-031 Op=111111 -> IllegalInstr pulse in DECODE, no strobes, InstrCount unchanged.
REQ-032 Reset low in MEM of sw, between clock edges -> MemWrite drops at once, state FETCH, InstrCount 0.
